// File: rtl/pulse_sign_gen.sv
// Step-pulse generator: emits PulseNum PUL pulses after a DIR setup delay.
// Optional macro SOFT_START_EN stretches the first three pulses (4x, 3x, 2x HALF_PERIOD).
module pulse_sign_gen #(
  parameter int HALF_PERIOD = 50,
  parameter int DIR_SETUP   = 10,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Enable,
  input  logic [CNT_W-1:0] PulseNum,
  input  logic             DR,
  output logic             PUL,
  output logic             DIR,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] PulseCount
);

`ifdef SOFT_START_EN
  localparam int PHASE_MAX = 4 * HALF_PERIOD;
`else
  localparam int PHASE_MAX = HALF_PERIOD;
`endif
  localparam int TMR_MAX = (PHASE_MAX > DIR_SETUP) ? PHASE_MAX : DIR_SETUP;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic [CNT_W-1:0]   remaining_reg, remaining_next;
  logic [CNT_W-1:0]   pulse_count_reg, pulse_count_next;
  logic               dir_reg, dir_next;
  logic [TMR_W-1:0]   phase_last;

  // Timer reload value for the phase being entered; pulse_count_reg is the
  // index of the pulse that the next HIGH or LOW phase belongs to.
  always_comb begin
    phase_last = TMR_W'(HALF_PERIOD - 1);
`ifdef SOFT_START_EN
    if (int'(pulse_count_reg) == 0)
      phase_last = TMR_W'(4 * HALF_PERIOD - 1);
    else if (int'(pulse_count_reg) == 1)
      phase_last = TMR_W'(3 * HALF_PERIOD - 1);
    else if (int'(pulse_count_reg) == 2)
      phase_last = TMR_W'(2 * HALF_PERIOD - 1);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    timer_next       = timer_reg;
    remaining_next   = remaining_reg;
    pulse_count_next = pulse_count_reg;
    dir_next         = dir_reg;
    PUL              = 1'b0;
    Busy             = 1'b1;
    Done             = 1'b0;
    case (state_reg)
      IDLE: begin
        Busy = 1'b0;
        if (Enable && (PulseNum != '0)) begin
          state_next       = SETUP;
          remaining_next   = PulseNum;
          dir_next         = DR;
          pulse_count_next = '0;
          timer_next       = TMR_W'(DIR_SETUP - 1);
        end
      end
      SETUP: begin
        if (timer_reg == '0) begin
          state_next = HIGH;
          timer_next = phase_last;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      HIGH: begin
        PUL = 1'b1;
        if (timer_reg == '0) begin
          state_next       = LOW;
          timer_next       = phase_last;
          remaining_next   = remaining_reg - 1'b1;
          pulse_count_next = pulse_count_reg + 1'b1;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      LOW: begin
        if (timer_reg == '0) begin
          state_next = (remaining_reg == '0) ? DONE : HIGH;
          timer_next = phase_last;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        Busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_reg       <= '0;
      remaining_reg   <= '0;
      pulse_count_reg <= '0;
      dir_reg         <= 1'b0;
    end else begin
      timer_reg       <= timer_next;
      remaining_reg   <= remaining_next;
      pulse_count_reg <= pulse_count_next;
      dir_reg         <= dir_next;
    end
  end

  assign DIR        = dir_reg;
  assign PulseCount = pulse_count_reg;

endmodule

// File: tb/tb_pulse_sign_gen.sv
// Bench for pulse_sign_gen: per-cycle comparison against a schedule-queue model,
// plus literal checks from hand-worked timelines (soft-start variant when SOFT_START_EN is defined).
module tb_pulse_sign_gen;
`ifdef SOFT_START_EN
  localparam int HP = 1;
`else
  localparam int HP = 2;
`endif
  localparam int DS    = 1;
  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             Enable = 1'b0;
  logic [CNT_W-1:0] PulseNum = '0;
  logic             DR = 1'b0;
  logic             PUL, DIR, Busy, Done;
  logic [CNT_W-1:0] PulseCount;

  int n_vec = 0;
  int n_err = 0;

  pulse_sign_gen #(.HALF_PERIOD(HP), .DIR_SETUP(DS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Enable(Enable), .PulseNum(PulseNum), .DR(DR),
    .PUL(PUL), .DIR(DIR), .Busy(Busy), .Done(Done), .PulseCount(PulseCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             pul;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;
  logic m_dir = 1'b0;

  function automatic exp_t mk(logic pul, logic busy, logic done, int cnt);
    exp_t e;
    e.pul = pul; e.busy = busy; e.done = done; e.cnt = CNT_W'(cnt);
    return e;
  endfunction

  // Length of each phase of pulse i (zero-based).
  function automatic int plen(int i);
`ifdef SOFT_START_EN
    if (i == 0) return 4 * HP;
    if (i == 1) return 3 * HP;
    if (i == 2) return 2 * HP;
`endif
    return HP;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  // Model: an accepted command expands into its full per-cycle output schedule.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        cur   = '0;
        m_dir = 1'b0;
      end else begin
        if (!cur.busy && Enable && PulseNum != '0) begin
          int n;
          n     = int'(PulseNum);
          m_dir = DR;
          for (int k = 0; k < DS; k++) q.push_back(mk(1'b0, 1'b1, 1'b0, 0));
          for (int i = 0; i < n; i++) begin
            for (int k = 0; k < plen(i); k++) q.push_back(mk(1'b1, 1'b1, 1'b0, i));
            for (int k = 0; k < plen(i); k++) q.push_back(mk(1'b0, 1'b1, 1'b0, i + 1));
          end
          q.push_back(mk(1'b0, 1'b1, 1'b1, n));
        end
        if (q.size() > 0) cur = q.pop_front();
        else begin
          cur.pul  = 1'b0;
          cur.busy = 1'b0;
          cur.done = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cycle", 32'({PUL, DIR, Busy, Done, PulseCount}),
          32'({cur.pul, m_dir, cur.busy, cur.done, cur.cnt}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(int budget);
    int k;
    k = 0;
    while (Busy && k < budget) begin
      step();
      k++;
    end
    chk("idle_within_budget", 32'(Busy), 32'(0));
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("reset_busy", 32'(Busy), 32'(0));
    chk("reset_dir_cnt", 32'({DIR, PulseCount}), 32'(0));

`ifndef SOFT_START_EN
    // 3-pulse command with an ignored request at cycle 5.
    Enable = 1'b1; PulseNum = 10'd3; DR = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      int ecnt;
      step();
      if (c == 1) Enable = 1'b0;
      if (c == 5) begin Enable = 1'b1; PulseNum = 10'd7; DR = 1'b0; end
      if (c == 6) Enable = 1'b0;
      ecnt = (c < 4) ? 0 : (c < 8) ? 1 : (c < 12) ? 2 : 3;
      chk("t1_pul", 32'(PUL), 32'(c == 2 || c == 3 || c == 6 || c == 7 || c == 10 || c == 11));
      chk("t1_busy", 32'(Busy), 32'(c <= 14));
      chk("t1_done", 32'(Done), 32'(c == 14));
      chk("t1_dir", 32'(DIR), 32'(1));
      chk("t1_cnt", 32'(PulseCount), 32'(ecnt));
    end
`else
    // Soft-start: PulseNum=5 must give high widths 4,3,2,1,1 and Done at cycle 24.
    begin
      int widths[$];
      int run;
      int done_c;
      run = 0; done_c = -1;
      Enable = 1'b1; PulseNum = 10'd5; DR = 1'b1;
      for (int c = 1; c <= 28; c++) begin
        step();
        if (c == 1) Enable = 1'b0;
        if (Done) done_c = c;
        if (PUL) run++;
        else if (run > 0) begin widths.push_back(run); run = 0; end
      end
      chk("ss_npulses", 32'(widths.size()), 32'(5));
      if (widths.size() == 5) begin
        chk("ss_w0", 32'(widths[0]), 32'(4));
        chk("ss_w1", 32'(widths[1]), 32'(3));
        chk("ss_w2", 32'(widths[2]), 32'(2));
        chk("ss_w3", 32'(widths[3]), 32'(1));
        chk("ss_w4", 32'(widths[4]), 32'(1));
      end
      chk("ss_done_cycle", 32'(done_c), 32'(24));
      chk("ss_cnt", 32'(PulseCount), 32'(5));
    end
`endif

    // Zero-length request is ignored.
    Enable = 1'b1; PulseNum = '0; DR = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      chk("zero_quiet", 32'({Busy, PUL, Done}), 32'(0));
    end
    chk("zero_dir", 32'(DIR), 32'(1));
    Enable = 1'b0;

`ifndef SOFT_START_EN
    // Held Enable retriggers in the first IDLE cycle after Done.
    Enable = 1'b1; PulseNum = 10'd1; DR = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 8) Enable = 1'b0;
      if (c == 1) chk("held_dir", 32'({Busy, DIR}), 32'(2));
      if (c == 6) chk("held_done", 32'(Done), 32'(1));
      if (c == 7) chk("held_idle", 32'({Busy, PulseCount}), 32'(1));
      if (c == 8) chk("held_restart", 32'({Busy, PulseCount}), 32'(11'h400));
      if (c == 11) chk("held_cnt", 32'(PulseCount), 32'(1));
    end
    wait_idle(200);
`endif

    // Reset mid-command, then a clean 2-pulse command.
    Enable = 1'b1; PulseNum = 10'd3; DR = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) Enable = 1'b0;
    end
`ifndef SOFT_START_EN
    chk("pre_reset_pul", 32'(PUL), 32'(1));
`endif
    rst = 1'b0;
    #1;
    chk("async_reset", 32'({PUL, Busy, DIR, Done, PulseCount}), 32'(0));
    step(); step();
    rst = 1'b1;
    step();
    Enable = 1'b1; PulseNum = 10'd2; DR = 1'b0;
    begin
      int pulses;
      logic prev;
      pulses = 0; prev = 1'b0;
      step();
      Enable = 1'b0;
      for (int k = 0; k < 500 && Busy; k++) begin
        if (PUL && !prev) pulses++;
        prev = PUL;
        step();
      end
      chk("post_reset_pulses", 32'(pulses), 32'(2));
      chk("post_reset_cnt", 32'(PulseCount), 32'(2));
    end

    // Maximum count must finish without wrapping.
    Enable = 1'b1; PulseNum = '1; DR = 1'b1;
    step();
    Enable = 1'b0;
    wait_idle(12000);
    chk("max_cnt", 32'(PulseCount), 32'(1023));

    // Random commands with occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      Enable   = ($urandom_range(0, 3) == 0);
      PulseNum = CNT_W'($urandom_range(0, 4));
      DR       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        step();
        rst = 1'b1;
      end
      step();
    end
    Enable = 1'b0;
    wait_idle(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/pulse_sign_gen.md
Name: pulse_sign_gen

Overview:
- Step-pulse generator stage directly downstream of the motor control block.
- Accepts a pulse count and a direction, then emits exactly that many PUL pulses on one motor channel, with a direction setup delay before the first pulse.
- Drives Busy back to the control block, which holds off new commands while Busy=1.

Parameters:
HALF_PERIOD, 50, clock cycles per PUL high phase and per PUL low phase (minimum 1).
DIR_SETUP, 10, clock cycles DIR is held stable before the first PUL rising edge (minimum 1).
CNT_W, 10, width of pulse count and progress counter.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
Enable  in  1  start request; sampled only in IDLE
PulseNum  in  CNT_W  number of pulses to emit
DR  in  1  direction request (1 reverse, 0 forward)
PUL  out  1  step pulse output
DIR  out  1  latched direction output
Busy  out  1  high while a command is in progress
Done  out  1  one-cycle strobe at command completion
PulseCount  out  CNT_W  pulses completed in current or last command

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately even mid-command): state=IDLE; PUL=0, DIR=0, Busy=0, Done=0, PulseCount=0; internal counters cleared.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE:
  - If Enable=1 and PulseNum!=0: latch PulseNum into the remaining counter and DR into DIR; clear PulseCount; next state SETUP.
  - If Enable=1 and PulseNum==0: ignore the request; no Busy, no Done.
- SETUP:
  - Busy=1, PUL=0; DIR is already updated in the first SETUP cycle.
  - Hold for DIR_SETUP cycles, then go to HIGH.
- HIGH: PUL=1 for HALF_PERIOD cycles, then go to LOW.
- LOW entry:
  - Decrement the remaining counter.
  - Increment PulseCount; the count is visible in the first LOW cycle.
- LOW: PUL=0 for HALF_PERIOD cycles. Then go to DONE if remaining==0, else back to HIGH.
- DONE: one cycle; Done=1, Busy=1, PUL=0. Next state IDLE, where Busy=0 and Done=0.
- Latency:
  - Enable sampled at cycle 0 gives Busy=1 and DIR valid at cycle 1.
  - First PUL rise at cycle 1+DIR_SETUP.
  - Busy total = DIR_SETUP + 2·HALF_PERIOD·N + 1 cycles.
- Command inputs: Enable, PulseNum and DR are ignored whenever state!=IDLE. A held Enable re-triggers in the first IDLE cycle after DONE.
- DIR holds its latched value in IDLE; it changes only at command acceptance.
- PulseCount holds its final value after DONE until the next accepted command.
- Width: PulseNum = 2^CNT_W−1 is legal. Counters must not wrap within a command.

Optional Feature:
Macro: SOFT_START_EN.
- Defined: the first three pulses of each command use high and low phases of 4·HALF_PERIOD, 3·HALF_PERIOD and 2·HALF_PERIOD respectively; all later pulses use HALF_PERIOD. If N<3, only the first N entries of this schedule are used. There is no deceleration ramp.
- Undefined: every phase is HALF_PERIOD; no extra logic is synthesized.

Test Plan:
- HALF_PERIOD=2, DIR_SETUP=1; Enable=1, PulseNum=3, DR=1 at cycle 0 → Busy=1 and DIR=1 at cycle 1; PUL=1 at cycles 2–3, 6–7, 10–11; PulseCount=1,2,3 at cycles 4, 8, 12; Done=1 at cycle 14; Busy=0 at cycle 15.
- Enable=1, PulseNum=0 → Busy, PUL and Done stay 0 for 20 cycles; DIR unchanged.
- During the above 3-pulse command, apply Enable=1, PulseNum=7, DR=0 at cycle 5 → ignored; exactly 3 pulses emitted and DIR stays 1.
- Enable held at 1 with PulseNum=1, DR=0 → second command accepted in the first IDLE cycle after Done; DIR=0; PulseCount resets to 0 then reaches 1.
- Drive rst=0 mid-HIGH on pulse 2 → PUL, Busy, DIR and PulseCount are 0 immediately; after release, state is IDLE and a new PulseNum=2 command emits exactly 2 pulses.
- SOFT_START_EN defined, HALF_PERIOD=1, PulseNum=5 → PUL high widths 4, 3, 2, 1, 1 cycles; Done asserted after the fifth low phase.
